// File: rtl/date_counter.sv
// Calendar date counter for years 2000-2099. It advances on the time counter's midnight
// pulse, and it supports a switch-driven set mode and a preset to 2099-12-31.
module date_counter #(
  parameter int unsigned RST_YEAR  = 0,
  parameter int unsigned RST_MONTH = 1,
  parameter int unsigned RST_DAY   = 1
) (
  input  logic       clk_1Hz,
  input  logic       rst,
  input  logic       day_increment,
  input  logic       sw0,
  input  logic       sw4,
  input  logic       sw5,
  input  logic       sw6,
  input  logic       sw7,
  output logic [6:0] year,
  output logic [3:0] month,
  output logic [4:0] day,
  output logic       leap,
  output logic       year_wrap,
  output logic       led_4,
  output logic       led_5,
  output logic       led_6
);

  logic [6:0] year_q, year_d;
  logic [3:0] month_q, month_d;
  logic [4:0] day_q, day_d;
  logic       year_wrap_q, year_wrap_d;
  logic [2:0] led_q, led_d;

  logic [6:0] adj_year;
  logic [3:0] adj_month;
  logic [4:0] adj_dim;
  logic [4:0] adj_day;
  logic [4:0] cur_dim;

  // Every year in 2000-2099 that is divisible by 4 is a leap year, so only the low bits matter.
  function automatic logic [4:0] dim_of(input logic [3:0] m, input logic [6:0] y);
    logic [4:0] d;
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
      4'd2:                    d = (y[1:0] == 2'd0) ? 5'd29 : 5'd28;
      default:                 d = 5'd31;
    endcase
    return d;
  endfunction

  // Set-mode datapath: year and month are adjusted first, and then day is adjusted against the new dim.
  always_comb begin
    cur_dim   = dim_of(month_q, year_q);
    adj_year  = year_q;
    adj_month = month_q;
    if (sw6) adj_year = (year_q == 7'd99) ? 7'd0 : year_q + 7'd1;
    if (sw5) adj_month = (month_q == 4'd12) ? 4'd1 : month_q + 4'd1;
    adj_dim = dim_of(adj_month, adj_year);
    adj_day = day_q;
    if (sw4) adj_day = (day_q >= adj_dim) ? 5'd1 : day_q + 5'd1;
    // Clamp so that a month or year change never leaves an impossible date
    if (adj_day > adj_dim) adj_day = adj_dim;
  end

  // Next-state selection with priority set mode > preset > normal count
  always_comb begin
    year_d      = year_q;
    month_d     = month_q;
    day_d       = day_q;
    year_wrap_d = 1'b0;
    led_d       = 3'b000;
    if (sw0) begin
      year_d  = adj_year;
      month_d = adj_month;
      day_d   = adj_day;
      led_d   = {sw6, sw5, sw4};
    end else if (sw7) begin
      year_d  = 7'd99;
      month_d = 4'd12;
      day_d   = 5'd31;
    end else if (day_increment) begin
      if (day_q < cur_dim) begin
        day_d = day_q + 5'd1;
      end else begin
        day_d = 5'd1;
        if (month_q == 4'd12) begin
          month_d = 4'd1;
          if (year_q == 7'd99) begin
            year_d      = 7'd0;
            year_wrap_d = 1'b1;
          end else begin
            year_d = year_q + 7'd1;
          end
        end else begin
          month_d = month_q + 4'd1;
        end
      end
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk_1Hz) begin
    if (rst) begin
      year_q      <= 7'(RST_YEAR);
      month_q     <= 4'(RST_MONTH);
      day_q       <= 5'(RST_DAY);
      year_wrap_q <= 1'b0;
      led_q       <= 3'b000;
    end else begin
      year_q      <= year_d;
      month_q     <= month_d;
      day_q       <= day_d;
      year_wrap_q <= year_wrap_d;
      led_q       <= led_d;
    end
  end

  // Output mapping
  always_comb begin
    year      = year_q;
    month     = month_q;
    day       = day_q;
    leap      = (year_q[1:0] == 2'd0);
    year_wrap = year_wrap_q;
    led_4     = led_q[0];
    led_5     = led_q[1];
    led_6     = led_q[2];
  end

endmodule

// File: tb/tb_date_counter.sv
// Testbench for date_counter: directed calendar scenarios, followed by randomized traffic
// that is checked against a calendar model.
module tb_date_counter;

  logic       clk_1Hz = 1'b0;
  logic       rst = 1'b0, day_increment = 1'b0;
  logic       sw0 = 1'b0, sw4 = 1'b0, sw5 = 1'b0, sw6 = 1'b0, sw7 = 1'b0;
  logic [6:0] year;
  logic [3:0] month;
  logic [4:0] day;
  logic       leap, year_wrap, led_4, led_5, led_6;

  int checks = 0;
  int errors = 0;

  // Calendar model: Gregorian date in the years 2000-2099, with the year stored as an offset
  int m_y, m_m, m_d, m_wrap, m_l4, m_l5, m_l6;

  date_counter dut (
    .clk_1Hz(clk_1Hz), .rst(rst), .day_increment(day_increment),
    .sw0(sw0), .sw4(sw4), .sw5(sw5), .sw6(sw6), .sw7(sw7),
    .year(year), .month(month), .day(day), .leap(leap), .year_wrap(year_wrap),
    .led_4(led_4), .led_5(led_5), .led_6(led_6)
  );

  always #5 clk_1Hz = ~clk_1Hz;

  function automatic int days_in(input int mo, input int yr);
    int tbl[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    int full;
    full = 2000 + yr;
    if (mo == 2 && ((full % 4 == 0 && full % 100 != 0) || full % 400 == 0)) return 29;
    return tbl[mo - 1];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, inc, s0, s4, s5, s6, s7);
    int dm;
    m_wrap = 0;
    if (r) begin
      m_y = 0; m_m = 1; m_d = 1; m_l4 = 0; m_l5 = 0; m_l6 = 0;
    end else if (s0) begin
      if (s6) m_y = (m_y + 1) % 100;
      if (s5) m_m = m_m % 12 + 1;
      dm = days_in(m_m, m_y);
      if (s4) m_d = (m_d >= dm) ? 1 : m_d + 1;
      if (m_d > dm) m_d = dm;
      m_l4 = s4; m_l5 = s5; m_l6 = s6;
    end else begin
      m_l4 = 0; m_l5 = 0; m_l6 = 0;
      if (s7) begin
        m_y = 99; m_m = 12; m_d = 31;
      end else if (inc) begin
        m_d++;
        if (m_d > days_in(m_m, m_y)) begin
          m_d = 1;
          m_m++;
          if (m_m > 12) begin
            m_m = 1;
            m_y++;
            if (m_y > 99) begin
              m_y = 0;
              m_wrap = 1;
            end
          end
        end
      end
    end
  endtask

  task automatic check_all();
    chk("year", 32'(year), m_y);
    chk("month", 32'(month), m_m);
    chk("day", 32'(day), m_d);
    chk("leap", 32'(leap), ((m_y % 4) == 0) ? 1 : 0);
    chk("year_wrap", 32'(year_wrap), m_wrap);
    chk("led_4", 32'(led_4), m_l4);
    chk("led_5", 32'(led_5), m_l5);
    chk("led_6", 32'(led_6), m_l6);
  endtask

  // One clock: drive the inputs away from the edge, update the model on the edge, and sample 1 time unit later
  task automatic tick(input logic r, inc, s0, s4, s5, s6, s7);
    rst = r; day_increment = inc; sw0 = s0; sw4 = s4; sw5 = s5; sw6 = s6; sw7 = s7;
    @(posedge clk_1Hz);
    model_step(r, inc, s0, s4, s5, s6, s7);
    #1;
    check_all();
  endtask

  // Reach a date from reset by single-step adjustments in set mode, starting from day 1 so no clamping occurs
  task automatic set_date(input int y, input int mo, input int d);
    tick(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < y; i++) tick(0, 0, 1, 0, 0, 1, 0);
    for (int i = 1; i < mo; i++) tick(0, 0, 1, 0, 1, 0, 0);
    for (int i = 1; i < d; i++) tick(0, 0, 1, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    m_y = 0; m_m = 1; m_d = 1; m_wrap = 0; m_l4 = 0; m_l5 = 0; m_l6 = 0;
    @(posedge clk_1Hz);
    #1;

    // Reset values
    tick(1, 1, 0, 0, 0, 0, 0);
    chk("rst_year", 32'(year), 0);
    chk("rst_month", 32'(month), 1);
    chk("rst_day", 32'(day), 1);
    chk("rst_leap", 32'(leap), 1);
    chk("rst_leds", 32'({led_6, led_5, led_4}), 0);
    chk("rst_wrap", 32'(year_wrap), 0);

    // Preset, then a midnight pulse wraps the century
    tick(0, 0, 0, 0, 0, 0, 1);
    chk("preset_y", 32'(year), 99);
    chk("preset_wrap", 32'(year_wrap), 0);
    tick(0, 1, 0, 0, 0, 0, 0);
    chk("wrap_date", 32'({year, month, day}), 32'({7'd0, 4'd1, 5'd1}));
    chk("wrap_pulse", 32'(year_wrap), 1);
    tick(0, 0, 0, 0, 0, 0, 0);
    chk("wrap_one_cycle", 32'(year_wrap), 0);

    // Leap and non-leap February
    set_date(24, 2, 28);
    tick(0, 1, 0, 0, 0, 0, 0);
    chk("leap_feb29", 32'({month, day}), 32'({4'd2, 5'd29}));
    tick(0, 1, 0, 0, 0, 0, 0);
    chk("leap_mar1", 32'({month, day}), 32'({4'd3, 5'd1}));
    set_date(23, 2, 28);
    tick(0, 1, 0, 0, 0, 0, 0);
    chk("nonleap_mar1", 32'({month, day}), 32'({4'd3, 5'd1}));

    // Month adjustment clamps the day to the new month's length
    set_date(0, 1, 31);
    tick(0, 0, 1, 0, 1, 0, 0);
    chk("clamp_month", 32'(month), 2);
    chk("clamp_day", 32'(day), 29);
    chk("clamp_led5", 32'(led_5), 1);

    // A pulse in set mode is dropped and is not replayed
    tick(0, 1, 1, 0, 0, 0, 0);
    chk("drop_day", 32'(day), 29);
    tick(0, 0, 0, 0, 0, 0, 0);
    chk("no_catchup", 32'({month, day}), 32'({4'd2, 5'd29}));

    // Day adjustment wraps at the end of the month, and reset overrides set mode
    set_date(0, 4, 30);
    tick(0, 0, 1, 1, 0, 0, 0);
    chk("dayadj_wrap", 32'({month, day}), 32'({4'd4, 5'd1}));
    tick(1, 0, 1, 1, 1, 1, 0);
    chk("rst_in_set", 32'({year, month, day}), 32'({7'd0, 4'd1, 5'd1}));
    chk("rst_in_set_leds", 32'({led_6, led_5, led_4}), 0);

    // Randomized traffic; the preset is frequent so that century wraps also occur
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 99) == 0), $urandom_range(0, 1),
           ($urandom_range(0, 3) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 1), ($urandom_range(0, 19) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/date_counter.md
DATE_COUNTER -- requirements
Module: date_counter

Interface
REQ-001 SHALL have parameter RST_YEAR, default 0, reset year offset from 2000 (0-99).
REQ-002 SHALL have parameter RST_MONTH, default 1, reset month (1-12).
REQ-003 SHALL have parameter RST_DAY, default 1, reset day (1 to days-in-month of RST_MONTH/RST_YEAR).
REQ-004 SHALL have port clk_1Hz, input, 1 bit: clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port day_increment, input, 1 bit: one-cycle pulse from the time counter on 23:59:59 -> 00:00:00.
REQ-007 SHALL have port sw0, input, 1 bit: set-mode enable (shared with the time counter).
REQ-008 SHALL have port sw4, input, 1 bit: day adjust in set mode.
REQ-009 SHALL have port sw5, input, 1 bit: month adjust in set mode.
REQ-010 SHALL have port sw6, input, 1 bit: year adjust in set mode.
REQ-011 SHALL have port sw7, input, 1 bit: preset to 2099-12-31 (pairs with the time preset 23:59:50).
REQ-012 SHALL have port year, output, 7 bits: year offset from 2000, range 0-99.
REQ-013 SHALL have port month, output, 4 bits: month, range 1-12.
REQ-014 SHALL have port day, output, 5 bits: day, range 1-31.
REQ-015 SHALL have port leap, output, 1 bit: 1 when year[1:0]==0; combinational from the year register.
REQ-016 SHALL have port year_wrap, output, 1 bit: registered one-cycle pulse on the 99 -> 0 rollover.
REQ-017 SHALL have ports led_4, led_5, led_6, outputs, 1 bit each: registered indicators for sw4/sw5/sw6 adjust activity.

Function
REQ-018 SHALL compute days-in-month (dim) as 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11; Feb 29 if leap, else 28.
REQ-019 SHALL apply per-cycle priority rst > sw0 > sw7 > normal count.
REQ-020 SHALL, in normal mode (sw0=0, sw7=0), on day_increment=1 with day<dim: set day+1.
REQ-021 SHALL, in normal mode on day_increment=1 with day==dim: set day=1 and month+1; if month==12, set month=1 and year+1; if year==99, set year=0.
REQ-022 SHALL assert year_wrap for exactly the cycle after the 99 -> 0 rollover edge; year_wrap SHALL be 0 in every other cycle, including set mode and preset.
REQ-023 SHALL hold day, month and year when day_increment=0 in normal mode.
REQ-024 SHALL ignore day_increment when sw0=1 or sw7=1; a dropped pulse SHALL NOT be replayed later.
REQ-025 SHALL, when sw7=1 and sw0=0, load year=99, month=12, day=31 each cycle sw7 is held.
REQ-026 SHALL, in set mode, on each cycle with sw6=1: year+1, with 99 wrapping to 0.
REQ-027 SHALL, in set mode, on each cycle with sw5=1: month+1, with 12 wrapping to 1.
REQ-028 SHALL, in set mode, on each cycle with sw4=1: day+1, wrapping to 1 after dim, where dim uses the post-adjust month and year of the same cycle.
REQ-029 SHALL apply sw4, sw5 and sw6 independently in the same cycle when asserted together; year and month are updated first, then day.
REQ-030 SHALL, after any set-mode update, clamp day to dim(new month, new year) if day exceeds it; the clamp SHALL take effect on the same edge.
REQ-031 SHALL drive led_4, led_5, led_6 = sw4, sw5, sw6 (registered, one-cycle latency) while sw0=1, and 0 while sw0=0.
REQ-032 SHALL never present an out-of-range value on year, month or day in any cycle after reset.

Reset
REQ-033 SHALL, on rst=1 at a clock edge, set year=RST_YEAR, month=RST_MONTH, day=RST_DAY, year_wrap=0, led_4=led_5=led_6=0, overriding all other inputs including a coincident day_increment.
REQ-034 SHALL NOT retain mid-operation state across reset; the first post-reset edge behaves as normal mode.

Verification
REQ-035 SHALL cover: rst=1 for 1 cycle -> year=0, month=1, day=1, leap=1, leds=0, year_wrap=0.
REQ-036 SHALL cover: sw7 for 1 cycle, then a day_increment pulse -> year=0, month=1, day=1, year_wrap=1 for exactly one cycle.
REQ-037 SHALL cover: year 24, 02-28, two pulses -> 02-29 then 03-01; year 23, 02-28, one pulse -> 03-01.
REQ-038 SHALL cover: year 0, 01-31, sw0=1, sw5=1 for one cycle -> month=2, day=29, led_5=1 on the following cycle.
REQ-039 SHALL cover: sw0=1 with a day_increment pulse -> date unchanged; after sw0 drops, no catch-up increment.
REQ-040 SHALL cover: 04-30, sw0=1, sw4=1 for one cycle -> day=1, month=4; rst asserted during sw0=1 -> reset values.
